// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one byte per cs_n frame with a CLK_DIV-cycle gap.
// Define SPI_MASTER_BURST_EN to allow back-to-back bytes inside one cs_n frame.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] div_cnt, div_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic       last_bit, last_nxt;
  logic [7:0] tx_sh, tx_sh_nxt;
  logic [7:0] rx_sh, rx_sh_nxt;
  logic [7:0] rx_data_nxt;
  logic       rx_valid_nxt;
  logic       busy_nxt;
  logic       sclk_nxt;
  logic       cs_n_nxt;
  logic       mosi_nxt;
  logic       div_end;

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic bit_in);
    return {sh[6:0], bit_in};
  endfunction

  assign div_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt    = state;
    div_nxt      = 8'd0;
    bit_nxt      = bit_cnt;
    last_nxt     = last_bit;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    busy_nxt     = busy;
    sclk_nxt     = sclk;
    cs_n_nxt     = cs_n;
    mosi_nxt     = mosi;

    if ((state != IDLE) && !div_end) begin
      div_nxt = div_cnt + 8'd1;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          tx_sh_nxt = tx_data;
          mosi_nxt  = tx_data[7];
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          bit_nxt   = 3'd0;
          last_nxt  = 1'b0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nxt = SHIFT_HI;
          sclk_nxt  = 1'b1;
          rx_sh_nxt = shift_in(rx_sh, miso);
          bit_nxt   = bit_cnt + 3'd1;
          last_nxt  = (bit_cnt == 3'd7);
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          state_nxt = SHIFT_LO;
          sclk_nxt  = 1'b0;
          tx_sh_nxt = {tx_sh[6:0], 1'b0};
          mosi_nxt  = tx_sh[6];
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          if (last_bit) begin
            // End of the cs_n hold low phase: the received byte is complete.
            rx_data_nxt  = rx_sh;
            rx_valid_nxt = 1'b1;
            bit_nxt      = 3'd0;
            last_nxt     = 1'b0;
            if (BURST_EN && start) begin
              tx_sh_nxt = tx_data;
              mosi_nxt  = tx_data[7];
            end else begin
              state_nxt = GAP;
              cs_n_nxt  = 1'b1;
              mosi_nxt  = 1'b0;
            end
          end else begin
            state_nxt = SHIFT_HI;
            sclk_nxt  = 1'b1;
            rx_sh_nxt = shift_in(rx_sh, miso);
            bit_nxt   = bit_cnt + 3'd1;
            last_nxt  = (bit_cnt == 3'd7);
          end
        end
      end
      GAP: begin
        if (div_end) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      last_bit <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      last_bit <= last_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
      sclk     <= sclk_nxt;
      cs_n     <= cs_n_nxt;
      mosi     <= mosi_nxt;
    end
  end

  // Shift registers are pure data; every transfer refills them completely.
  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_nxt;
    rx_sh <= rx_sh_nxt;
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table vectors, random transfers against an SPI slave model,
// plus reset, held-start, back-to-back and CLK_DIV=2 timing sequences.
module tb_spi_master;
  localparam int D  = 4;
  localparam int D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, miso, busy, rx_valid, sclk, cs_n, mosi;
  logic [7:0] tx_data, rx_data;
  logic       start2, busy2, rx_valid2, sclk2, cs_n2, mosi2;
  logic [7:0] tx_data2, rx_data2;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2), .busy(busy2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .sclk(sclk2), .cs_n(cs_n2),
    .mosi(mosi2), .miso(1'b1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI mode-0 slave: presents MSB when selected, advances on sclk falls, samples mosi on rises.
  logic       idle_noise = 1'b0;
  logic [7:0] cur        = 8'h00;
  logic [2:0] idx        = 3'd0;
  logic       cs_q       = 1'b1;
  logic       sclk_q     = 1'b0;
  logic [7:0] ret_arr [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       mosi_q [$];

  assign miso = cs_n ? idle_noise : cur[~idx];

  always @(negedge clk) begin
    cs_q   <= cs_n;
    sclk_q <= sclk;
    if (cs_q == 1'b1 && cs_n == 1'b0) begin
      idx <= 3'd0;
      if (rd_ptr < wr_ptr) begin
        cur    <= ret_arr[rd_ptr[5:0]];
        rd_ptr <= rd_ptr + 1;
      end else begin
        cur <= 8'h00;
      end
    end else if (cs_n == 1'b0 && sclk_q == 1'b1 && sclk == 1'b0) begin
      if (idx == 3'd7) begin
        idx <= 3'd0;
        if (rd_ptr < wr_ptr) begin
          cur    <= ret_arr[rd_ptr[5:0]];
          rd_ptr <= rd_ptr + 1;
        end else begin
          cur <= 8'h00;
        end
      end else begin
        idx <= idx + 3'd1;
      end
    end
    if (cs_n == 1'b0 && sclk_q == 1'b0 && sclk == 1'b1) mosi_q.push_back(mosi);
  end

  int         cs_low = 0, busy_n = 0, rxv_n = 0, frames = 0, sclk_bad = 0, rises = 0;
  int         rxv_t [$];
  logic [7:0] rxv_d [$];
  always @(negedge clk) begin
    if (cs_n == 1'b0) cs_low <= cs_low + 1;
    if (busy == 1'b1) busy_n <= busy_n + 1;
    if (rx_valid == 1'b1) begin
      rxv_n <= rxv_n + 1;
      rxv_t.push_back(cyc);
      rxv_d.push_back(rx_data);
    end
    if (cs_n == 1'b1 && sclk == 1'b1) sclk_bad <= sclk_bad + 1;
    if (cs_q == 1'b1 && cs_n == 1'b0) frames <= frames + 1;
    if (cs_n == 1'b0 && sclk_q == 1'b0 && sclk == 1'b1) rises <= rises + 1;
  end

  logic s2q  = 1'b0;
  int   hrun = 0;
  int   cs2_low = 0;
  int   r2_t [$];
  int   hi_q [$];
  always @(negedge clk) begin
    s2q <= sclk2;
    if (cs_n2 == 1'b0) cs2_low <= cs2_low + 1;
    if (s2q == 1'b0 && sclk2 == 1'b1) r2_t.push_back(cyc);
    if (sclk2 == 1'b1) hrun <= hrun + 1;
    else if (s2q == 1'b1) begin
      hi_q.push_back(hrun);
      hrun <= 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  logic r_to;
  int   r_cs, r_busy, r_nv, r_fr, r_nb;
  logic [7:0] r_mo, r_rx, r_rxv;

  task automatic wait_idle();
    r_to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (busy == 1'b0) begin
        r_to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input logic [7:0] ret);
    ret_arr[wr_ptr[5:0]] = ret;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] ret);
    int c0, b0, v0, f0, m0;
    push_ret(ret);
    c0 = cs_low; b0 = busy_n; v0 = rxv_n; f0 = frames; m0 = mosi_q.size();
    @(negedge clk);
    start = 1'b1; tx_data = tx;
    @(negedge clk);
    start = 1'b0; tx_data = 8'($urandom);
    wait_idle();
    r_cs = cs_low - c0; r_busy = busy_n - b0; r_nv = rxv_n - v0; r_fr = frames - f0;
    r_nb = mosi_q.size() - m0;
    r_mo = 8'h00;
    if (r_nb >= 8) for (int i = 0; i < 8; i++) r_mo = {r_mo[6:0], mosi_q[m0 + i]};
    r_rx  = rx_data;
    r_rxv = (rxv_d.size() > 0) ? rxv_d[rxv_d.size() - 1] : 8'h00;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] ret;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_cs;
    int         exp_busy;
  } vec_t;

  vec_t vt [5];

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, v0, f0, b0, rs0, m0, r0, h0, nbad;
    logic [7:0] tx, ret;

    vt[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 68, 72};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 68, 72};
    vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 68, 72};
    vt[3] = '{8'h80, 8'h01, 8'h01, 8'h80, 68, 72};
    vt[4] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A, 68, 72};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; start2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_busy2", int'(busy2), 0);

    for (int k = 0; k < 5; k++) begin
      xfer(vt[k].tx, vt[k].ret);
      chk($sformatf("vec%0d_done", k), int'(r_to), 0);
      chk($sformatf("vec%0d_rx_data", k), int'(r_rx), int'(vt[k].exp_rx));
      chk($sformatf("vec%0d_rx_at_valid", k), int'(r_rxv), int'(vt[k].exp_rx));
      chk($sformatf("vec%0d_mosi_byte", k), int'(r_mo), int'(vt[k].exp_mosi));
      chk($sformatf("vec%0d_mosi_bits", k), r_nb, 8);
      chk($sformatf("vec%0d_cs_low", k), r_cs, vt[k].exp_cs);
      chk($sformatf("vec%0d_busy_len", k), r_busy, vt[k].exp_busy);
      chk($sformatf("vec%0d_rx_valid_cnt", k), r_nv, 1);
      chk($sformatf("vec%0d_frames", k), r_fr, 1);
      chk($sformatf("vec%0d_idle_mosi", k), int'(mosi), 0);
      chk($sformatf("vec%0d_idle_sclk", k), int'(sclk), 0);
    end

    for (int k = 0; k < 8; k++) begin
      tx = 8'($urandom); ret = 8'($urandom);
      xfer(tx, ret);
      chk($sformatf("rnd%0d_done", k), int'(r_to), 0);
      chk($sformatf("rnd%0d_rx_data", k), int'(r_rx), int'(ret));
      chk($sformatf("rnd%0d_mosi_byte", k), int'(r_mo), int'(tx));
      chk($sformatf("rnd%0d_cs_low", k), r_cs, 17 * D);
      chk($sformatf("rnd%0d_busy_len", k), r_busy, 18 * D);
      chk($sformatf("rnd%0d_rx_valid_cnt", k), r_nv, 1);
      repeat ($urandom_range(3, 15)) begin
        @(negedge clk);
        idle_noise = 1'($urandom);
      end
      chk($sformatf("rnd%0d_rx_hold", k), int'(rx_data), int'(ret));
    end

    // start held for three cycles yields one transfer
    push_ret(8'hC3);
    c0 = cs_low; b0 = busy_n; f0 = frames;
    @(negedge clk);
    start = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    chk("hold_busy_next", int'(busy), 1);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    chk("hold_done", int'(r_to), 0);
    chk("hold_frames", frames - f0, 1);
    chk("hold_busy_len", busy_n - b0, 18 * D);
    chk("hold_cs_low", cs_low - c0, 17 * D);
    chk("hold_rx_data", int'(rx_data), 8'hC3);

    // reset at the fourth sclk rise
    push_ret(8'hFF);
    v0 = rxv_n; rs0 = rises;
    @(negedge clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (7 * D - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", int'(cs_n), 1);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    chk("abort_rx_valid_cnt", rxv_n - v0, 0);
    chk("abort_rises", rises - rs0, 3);
    chk("abort_rx_data", int'(rx_data), 0);

    // reset wins over start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; tx_data = 8'hAA;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_dom_busy", int'(busy), 0);
    chk("rst_dom_cs_n", int'(cs_n), 1);
    @(negedge clk);
    chk("rst_dom_busy_after", int'(busy), 0);

    // second start on the final hold cycle
    push_ret(8'h96); push_ret(8'h69);
    c0 = cs_low; v0 = rxv_n; f0 = frames; b0 = busy_n; m0 = mosi_q.size();
    @(negedge clk);
    start = 1'b1; tx_data = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (17 * D - 1) @(negedge clk);
    start = 1'b1; tx_data = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    chk("b2b_done", int'(r_to), 0);
    chk("b2b_frames", frames - f0, 1);
    r_mo = 8'h00;
    if (mosi_q.size() >= m0 + 8) for (int i = 0; i < 8; i++) r_mo = {r_mo[6:0], mosi_q[m0 + i]};
    chk("b2b_mosi_first", int'(r_mo), 8'h11);
`ifdef SPI_MASTER_BURST_EN
    chk("burst_cs_low", cs_low - c0, 34 * D);
    chk("burst_rx_valid_cnt", rxv_n - v0, 2);
    chk("burst_mosi_bits", mosi_q.size() - m0, 16);
    r_mo = 8'h00;
    if (mosi_q.size() >= m0 + 16) for (int i = 8; i < 16; i++) r_mo = {r_mo[6:0], mosi_q[m0 + i]};
    chk("burst_mosi_second", int'(r_mo), 8'h22);
    if (rxv_d.size() >= 2) begin
      chk("burst_rx_first", int'(rxv_d[rxv_d.size() - 2]), 8'h96);
      chk("burst_rx_second", int'(rxv_d[rxv_d.size() - 1]), 8'h69);
      // leading low half plus eight full sclk periods per byte
      chk("burst_valid_spacing", rxv_t[rxv_t.size() - 1] - rxv_t[rxv_t.size() - 2], D + 16 * D);
    end
`else
    chk("single_cs_low", cs_low - c0, 17 * D);
    chk("single_rx_valid_cnt", rxv_n - v0, 1);
    chk("single_mosi_bits", mosi_q.size() - m0, 8);
    chk("single_busy_len", busy_n - b0, 18 * D);
    chk("single_rx_data", int'(rx_data), 8'h96);
`endif

    // CLK_DIV=2 instance with miso tied high
    c0 = cs2_low; r0 = r2_t.size(); h0 = hi_q.size();
    @(negedge clk);
    start2 = 1'b1; tx_data2 = 8'($urandom);
    @(negedge clk);
    start2 = 1'b0;
    r_to = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (busy2 == 1'b0) begin
        r_to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("div2_done", int'(r_to), 0);
    chk("div2_rx_data", int'(rx_data2), 8'hFF);
    chk("div2_cs_low", cs2_low - c0, 17 * D2);
    chk("div2_rises", r2_t.size() - r0, 8);
    chk("div2_high_runs", hi_q.size() - h0, 8);
    nbad = 0;
    for (int i = r0 + 1; i < r2_t.size(); i++) if (r2_t[i] - r2_t[i - 1] != 2 * D2) nbad++;
    chk("div2_period_bad", nbad, 0);
    nbad = 0;
    for (int i = h0; i < hi_q.size(); i++) if (hi_q[i] != D2) nbad++;
    chk("div2_high_bad", nbad, 0);

    chk("sclk_high_while_deselected", sclk_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
